uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 271 +++++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampling UART receiver with majority vote and show-ahead receive FIFO
//
// Receives asynchronous serial frames on i_rx, timed by the shared OVS x baud tick.
// Each frame is a start bit, DATA_BITS data bits sent LSB first, an optional parity
// bit and STOP_BITS stop bits. Every bit is decided by a 2-of-3 vote around mid-bit.
// Each received word is stored with its break, frame and parity flags in a
// FIFO_DEPTH-entry show-ahead FIFO.
//
// Ports:
//   i_clk, i_rst    system clock; asynchronous active-high reset
//   i_baud_tick     one-cycle strobe at OVS x baud rate
//   i_rx            asynchronous serial input, idle high
//   i_ready         pop request; acted on only when o_valid is high
//   i_ovr_clr       pulse that clears o_overrun
//   o_data          data of the FIFO head word (0 when empty)
//   o_valid         FIFO holds at least one word
//   o_parity_err    head word failed its parity check
//   o_frame_err     head word had a 0 stop bit
//   o_break         head word is a break (all-zero frame)
//   o_overrun       sticky: a word was dropped because the FIFO was full
//   o_bsy           receiver is not idle
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVS        = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_baud_tick,
  input  logic                 i_rx,
  input  logic                 i_ready,
  input  logic                 i_ovr_clr,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_overrun,
  output logic                 o_bsy
);

  localparam int CW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = DATA_BITS + 3;

  localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(OVS / 2);
  localparam logic [CW-1:0] CNT_S2   = CW'(OVS / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRKWAIT
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser. sync3_q is only used for falling-edge detection.
  // ---------------------------------------------------------------------------
  logic sync1_q, sync2_q, sync3_q;
  logic rx_s, rx_fall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= i_rx;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rx_s    = sync2_q;
  assign rx_fall = sync3_q & ~sync2_q;

  // ---------------------------------------------------------------------------
  // Receiver state
  // ---------------------------------------------------------------------------
  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic                   samp0_q, samp1_q;
  logic                   vote_q;
  logic [BW-1:0]          bit_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_bit_q;
  logic                   stop1_q;
  logic                   stop_idx_q;
  logic                   commit_q;
  logic [WW-1:0]          cword_q;
  logic                   bsy_q;

  logic in_frame, bit_end, vote_done, vote_now;
  logic first_stop, final_stop, fin_ferr, fin_brk, fin_perr, ones_odd;

  assign in_frame  = (state_q == S_START) || (state_q == S_DATA) ||
                     (state_q == S_PARITY) || (state_q == S_STOP);
  assign bit_end   = i_baud_tick && (cnt_q == CNT_LAST);
  assign vote_done = i_baud_tick && (cnt_q == CNT_S2);
  // The third sample is the live synchronised value, so the vote is usable
  // in the same cycle as the third tick.
  assign vote_now  = (samp0_q & samp1_q) | (samp0_q & rx_s) | (samp1_q & rx_s);

  // End-of-frame decision. The first stop bit is held in stop1_q when a second
  // stop bit follows; otherwise the live vote is the first (and only) stop bit.
  always_comb begin
    first_stop = (STOP_BITS == 2) ? stop1_q : vote_now;
    final_stop = vote_done && ((STOP_BITS == 1) || stop_idx_q);
    fin_ferr   = ~first_stop | ~vote_now;
    fin_brk    = (shift_q == '0) && ((PARITY == 0) || !par_bit_q) && !first_stop;
    ones_odd   = (^shift_q) ^ par_bit_q;
    fin_perr   = 1'b0;
    if (PARITY == 1) fin_perr = ~ones_odd;
    if (PARITY == 2) fin_perr = ones_odd;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      samp0_q    <= 1'b1;
      samp1_q    <= 1'b1;
      vote_q     <= 1'b1;
      bit_q      <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      stop1_q    <= 1'b1;
      stop_idx_q <= 1'b0;
      commit_q   <= 1'b0;
      cword_q    <= '0;
      bsy_q      <= 1'b0;
    end else begin
      commit_q <= 1'b0;

      if (i_baud_tick && in_frame) begin
        cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        if (cnt_q == CNT_S0) samp0_q <= rx_s;
        if (cnt_q == CNT_S1) samp1_q <= rx_s;
        if (cnt_q == CNT_S2) vote_q  <= vote_now;
      end

      case (state_q)
        S_IDLE: begin
          if (rx_fall) begin
            state_q <= S_START;
            cnt_q   <= '0;
            bsy_q   <= 1'b1;
          end
        end

        S_START: begin
          // A start bit that votes high was a glitch; abandon it early.
          if (vote_done && vote_now) begin
            state_q <= S_IDLE;
            bsy_q   <= 1'b0;
          end else if (bit_end) begin
            state_q <= S_DATA;
            bit_q   <= '0;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            shift_q <= {vote_q, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
              state_q    <= (PARITY != 0) ? S_PARITY : S_STOP;
              stop_idx_q <= 1'b0;
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            par_bit_q  <= vote_q;
            state_q    <= S_STOP;
            stop_idx_q <= 1'b0;
          end
        end

        S_STOP: begin
          // Stop bits are decided at vote completion rather than at bit end so
          // the receiver is back in IDLE before the next start edge can arrive.
          if (final_stop) begin
            commit_q <= 1'b1;
            cword_q  <= {fin_brk, fin_ferr | fin_brk, fin_perr, shift_q};
            state_q  <= (fin_ferr | fin_brk) ? S_BRKWAIT : S_IDLE;
            bsy_q    <= fin_ferr | fin_brk;
          end else if (vote_done) begin
            stop1_q    <= vote_now;
            stop_idx_q <= 1'b1;
          end
        end

        S_BRKWAIT: begin
          // Hold off until the line is released so a long low level yields one word.
          if (rx_s) begin
            state_q <= S_IDLE;
            bsy_q   <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          bsy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_bsy = bsy_q;

  // ---------------------------------------------------------------------------
  // Show-ahead receive FIFO. Pointers carry one extra wrap bit.
  // ---------------------------------------------------------------------------
  logic [WW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_q, rd_q, wr_d, rd_d;
  logic          ovr_q, ovr_d;
  logic          empty, full, pop, push_ok, drop;
  logic [WW-1:0] head;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = ~empty & i_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still fits.
  assign push_ok = commit_q & (~full | pop);
  assign drop    = commit_q & full & ~pop;

  always_comb begin
    wr_d  = wr_q + {{AW{1'b0}}, push_ok};
    rd_d  = rd_q + {{AW{1'b0}}, pop};
    ovr_d = ovr_q;
    if (i_ovr_clr) ovr_d = 1'b0;
    if (drop)      ovr_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovr_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovr_q <= ovr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= cword_q;
  end

  // Outputs are forced to 0 while empty so stale storage never shows.
  assign head         = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign o_valid      = ~empty;
  assign o_data       = head[DATA_BITS-1:0];
  assign o_parity_err = head[DATA_BITS];
  assign o_frame_err  = head[DATA_BITS+1];
  assign o_break      = head[DATA_BITS+2];
  assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo (8N1 and 8E2 instances)
module tb_uart_rx_fifo;

  localparam int BIT_CLK = 64;  // 16 ticks per bit, one tick every 4 clocks

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;

  logic       rx0 = 1'b1, rdy0 = 1'b0, clr0 = 1'b0;
  logic [7:0] d0;
  logic       v0, pe0, fe0, br0, ov0, bsy0;

  logic       rx1 = 1'b1, rdy1 = 1'b0, clr1 = 1'b0;
  logic [7:0] d1;
  logic       v1, pe1, fe1, br1, ov1, bsy1;

  int total = 0;
  int bad   = 0;

  uart_rx_fifo #(.DATA_BITS(8), .OVS(16), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_baud_tick(tick), .i_rx(rx0), .i_ready(rdy0),
    .i_ovr_clr(clr0), .o_data(d0), .o_valid(v0), .o_parity_err(pe0),
    .o_frame_err(fe0), .o_break(br0), .o_overrun(ov0), .o_bsy(bsy0)
  );

  uart_rx_fifo #(.DATA_BITS(8), .OVS(16), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_p (
    .i_clk(clk), .i_rst(rst), .i_baud_tick(tick), .i_rx(rx1), .i_ready(rdy1),
    .i_ovr_clr(clr1), .o_data(d1), .o_valid(v1), .o_parity_err(pe1),
    .o_frame_err(fe1), .o_break(br1), .o_overrun(ov1), .o_bsy(bsy1)
  );

  always #5 clk = ~clk;

  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      tick = (k == 3);
      k = (k + 1) % 4;
    end
  end

  // Reference: the word a frame should produce, from the framing rules.
  function automatic logic [10:0] model_word(input logic [7:0] data, input int pmode,
                                             input logic pbit, input logic s1,
                                             input logic s2, input int nstop);
    int   ones;
    logic pe, fe, brk;
    ones = $countones(data) + int'(pbit);
    pe   = (pmode == 1) ? (ones % 2 == 0) : (pmode == 2) ? (ones % 2 == 1) : 1'b0;
    brk  = (data == 8'h00) && (pmode == 0 || pbit == 1'b0) && !s1;
    fe   = !s1 || (nstop == 2 && !s2) || brk;
    return {brk, fe, pe, data};
  endfunction

  function automatic logic [10:0] head_word(input int which);
    return (which == 0) ? {br0, fe0, pe0, d0} : {br1, fe1, pe1, d1};
  endfunction

  task automatic drive_bit(input int which, input logic val);
    if (which == 0) rx0 = val; else rx1 = val;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int which, input int nbits);
    for (int i = 0; i < nbits; i++) drive_bit(which, 1'b1);
  endtask

  task automatic send_frame(input int which, input logic [7:0] data, input logic has_par,
                            input logic pbit, input logic s1, input logic s2,
                            input logic two_stop);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, data[i]);
    if (has_par) drive_bit(which, pbit);
    drive_bit(which, s1);
    if (two_stop) drive_bit(which, s2);
  endtask

  task automatic wait_valid(input int which, input int max_cyc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      ok = (which == 0) ? v0 : v1;
    end
  endtask

  // Called from a negedge; the pop happens on the following posedge.
  task automatic pop(input int which);
    if (which == 0) rdy0 = 1'b1; else rdy1 = 1'b1;
    @(posedge clk);
    #1;
    rdy0 = 1'b0;
    rdy1 = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({v0, d0, pe0, fe0, br0, ov0, bsy0} !== 14'd0) begin
      bad++;
      $display("FAIL reset_dut0 got=%b exp=0", {v0, d0, pe0, fe0, br0, ov0, bsy0});
    end
    total++;
    if ({v1, d1, pe1, fe1, br1, ov1, bsy1} !== 14'd0) begin
      bad++;
      $display("FAIL reset_dut1 got=%b exp=0", {v1, d1, pe1, fe1, br1, ov1, bsy1});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(0, 1);
  endtask

  task automatic test_basic;
    logic ok;
    logic [10:0] exp;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp = model_word(8'hA5, 0, 1'b0, 1'b1, 1'b1, 1);
    wait_valid(0, 200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_valid got=0 exp=1"); end
    total++;
    if (head_word(0) !== exp) begin
      bad++; $display("FAIL basic_word got=%h exp=%h", head_word(0), exp);
    end
    total++;
    if (bsy0 !== 1'b0) begin bad++; $display("FAIL basic_bsy got=%b exp=0", bsy0); end
    pop(0);
    @(negedge clk);
    total++;
    if (v0 !== 1'b0) begin bad++; $display("FAIL basic_popped got=%b exp=0", v0); end
  endtask

  task automatic test_false_start;
    logic saw;
    saw = 1'b0;
    rx0 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rx0 = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (bsy0) saw = 1'b1;
    end
    total++;
    if (saw !== 1'b1) begin bad++; $display("FAIL false_start_bsy_pulse got=%b exp=1", saw); end
    total++;
    if ({bsy0, v0} !== 2'b00) begin
      bad++; $display("FAIL false_start_idle got=%b exp=00", {bsy0, v0});
    end
    idle(0, 1);
  endtask

  task automatic test_parity;
    logic ok;
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_valid(1, 200, ok);
    total++;
    if (!ok || head_word(1) !== {3'b001, 8'h03}) begin
      bad++; $display("FAIL parity_bad got=%h exp=%h", head_word(1), {3'b001, 8'h03});
    end
    pop(1);
    idle(1, 1);
    send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_valid(1, 200, ok);
    total++;
    if (!ok || head_word(1) !== {3'b000, 8'h03}) begin
      bad++; $display("FAIL parity_good got=%h exp=%h", head_word(1), {3'b000, 8'h03});
    end
    pop(1);
    idle(1, 1);
  endtask

  task automatic test_frame_err;
    logic ok;
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_valid(0, 200, ok);
    total++;
    if (!ok || head_word(0) !== {3'b010, 8'h55}) begin
      bad++; $display("FAIL frame_err_word got=%h exp=%h", head_word(0), {3'b010, 8'h55});
    end
    pop(0);
    repeat (3 * BIT_CLK) @(negedge clk);
    total++;
    if (bsy0 !== 1'b1) begin bad++; $display("FAIL frame_err_brkwait got=%b exp=1", bsy0); end
    idle(0, 1);
    @(negedge clk);
    total++;
    if (bsy0 !== 1'b0) begin bad++; $display("FAIL frame_err_release got=%b exp=0", bsy0); end
    send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_valid(0, 200, ok);
    total++;
    if (!ok || head_word(0) !== {3'b000, 8'h12}) begin
      bad++; $display("FAIL frame_err_next got=%h exp=%h", head_word(0), {3'b000, 8'h12});
    end
    pop(0);
    idle(0, 1);
  endtask

  task automatic test_break;
    logic ok;
    rx0 = 1'b0;
    repeat (20 * BIT_CLK) @(posedge clk);
    #1;
    wait_valid(0, 10, ok);
    total++;
    if (!ok || head_word(0) !== {3'b110, 8'h00}) begin
      bad++; $display("FAIL break_word got=%h exp=%h", head_word(0), {3'b110, 8'h00});
    end
    pop(0);
    @(negedge clk);
    total++;
    if ({v0, bsy0} !== 2'b01) begin
      bad++; $display("FAIL break_single got=%b exp=01", {v0, bsy0});
    end
    idle(0, 2);
    @(negedge clk);
    total++;
    if ({v0, bsy0} !== 2'b00) begin
      bad++; $display("FAIL break_after_release got=%b exp=00", {v0, bsy0});
    end
  endtask

  task automatic test_overrun;
    logic ok;
    logic [7:0] q[$];
    logic [7:0] b;
    for (int i = 1; i <= 5; i++) begin
      send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      if (i <= 4) q.push_back(8'(i));
    end
    idle(0, 1);
    @(negedge clk);
    total++;
    if (ov0 !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b exp=1", ov0); end
    while (q.size() > 0) begin
      b = q.pop_front();
      wait_valid(0, 10, ok);
      total++;
      if (!ok || head_word(0) !== {3'b000, b}) begin
        bad++; $display("FAIL overrun_pop got=%h exp=%h", head_word(0), {3'b000, b});
      end
      pop(0);
    end
    rdy0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rdy0 = 1'b0;
    @(negedge clk);
    total++;
    if ({v0, ov0} !== 2'b01) begin
      bad++; $display("FAIL overrun_empty_pop got=%b exp=01", {v0, ov0});
    end
    clr0 = 1'b1;
    @(posedge clk);
    #1;
    clr0 = 1'b0;
    @(negedge clk);
    total++;
    if (ov0 !== 1'b0) begin bad++; $display("FAIL overrun_clear got=%b exp=0", ov0); end
    b = 8'($urandom);
    send_frame(0, b, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_valid(0, 200, ok);
    total++;
    if (!ok || head_word(0) !== {3'b000, b}) begin
      bad++; $display("FAIL overrun_resume got=%h exp=%h", head_word(0), {3'b000, b});
    end
    pop(0);
    idle(0, 1);
  endtask

  task automatic test_back_to_back;
    logic ok;
    logic [10:0] q[$];
    logic [10:0] exp;
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      send_frame(0, b, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      q.push_back(model_word(b, 0, 1'b0, 1'b1, 1'b1, 1));
    end
    idle(0, 1);
    while (q.size() > 0) begin
      exp = q.pop_front();
      wait_valid(0, 10, ok);
      total++;
      if (!ok || head_word(0) !== exp) begin
        bad++; $display("FAIL b2b_word got=%h exp=%h", head_word(0), exp);
      end
      pop(0);
    end
    @(negedge clk);
    total++;
    if (v0 !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", v0); end
  endtask

  task automatic test_random_parity;
    logic ok;
    logic [7:0] b;
    logic pb, s1, s2;
    logic [10:0] exp;
    for (int i = 0; i < 6; i++) begin
      b  = 8'($urandom);
      pb = 1'($urandom);
      s1 = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 3) != 0);
      exp = model_word(b, 2, pb, s1, s2, 2);
      send_frame(1, b, 1'b1, pb, s1, s2, 1'b1);
      idle(1, 1);
      wait_valid(1, 10, ok);
      total++;
      if (!ok || head_word(1) !== exp) begin
        bad++; $display("FAIL rand_parity_word got=%h exp=%h", head_word(1), exp);
      end
      pop(1);
    end
  endtask

  task automatic test_reset_mid;
    logic ok;
    send_frame(0, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(0, 1);
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'($urandom));
    rx0 = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({v0, bsy0} !== 2'b00) begin
      bad++; $display("FAIL reset_mid_outputs got=%b exp=00", {v0, bsy0});
    end
    rx0 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(0, 1);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_valid(0, 200, ok);
    total++;
    if (!ok || head_word(0) !== {3'b000, 8'h3C}) begin
      bad++; $display("FAIL reset_mid_next got=%h exp=%h", head_word(0), {3'b000, 8'h3C});
    end
    pop(0);
    @(negedge clk);
    total++;
    if (v0 !== 1'b0) begin bad++; $display("FAIL reset_mid_single got=%b exp=0", v0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_parity();
    test_frame_err();
    test_break();
    test_overrun();
    test_back_to_back();
    test_random_parity();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
